// File: rtl/ccl_readout_ctrl.sv
// Frame sequencer for the CCL labeler: it gates ccl_en, drains the pipeline, then reads centroids out on a valid/ready stream.
// Optional feature: define CCL_AREA_FILTER_EN to skip labels whose area is below MIN_AREA.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef LOC_SIZE
`define LOC_SIZE 10
`endif
`ifndef OBJ_WIDTH
`define OBJ_WIDTH 16
`endif

module ccl_readout_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int READ_LAT     = 1,
  parameter int MIN_AREA     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  pix_valid,
  input  logic [`WORD_SIZE-1:0] num_labels,
  input  logic [`LOC_SIZE-1:0]  obj_x,
  input  logic [`LOC_SIZE-1:0]  obj_y,
  input  logic [`OBJ_WIDTH-1:0] obj_area,
  output logic                  ccl_en,
  output logic [`WORD_SIZE-1:0] obj_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [`WORD_SIZE-1:0] out_label,
  output logic [`LOC_SIZE-1:0]  out_x,
  output logic [`LOC_SIZE-1:0]  out_y,
  output logic                  busy,
  output logic                  done,
  output logic [`WORD_SIZE-1:0] obj_count
);

  localparam int WORD_W  = `WORD_SIZE;
  localparam int LOC_W   = `LOC_SIZE;
  localparam int OBJ_W   = `OBJ_WIDTH;
  localparam int CNT_MAX = (DRAIN_CYCLES > READ_LAT + 1) ? DRAIN_CYCLES : READ_LAT + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef CCL_AREA_FILTER_EN
  localparam bit AREA_FILTER = 1'b1;
`else
  localparam bit AREA_FILTER = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_FETCH,
    S_EMIT
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [WORD_W-1:0]   n_lat, n_lat_nxt;
  logic [WORD_W-1:0]   obj_id_nxt;
  logic                out_valid_nxt;
  logic [WORD_W-1:0]   out_label_nxt;
  logic [LOC_W-1:0]    out_x_nxt, out_y_nxt;
  logic [WORD_W-1:0]   obj_count_nxt;
  logic                done_nxt;
  logic                last_label;
  logic                keep_label;

  // An empty object has no meaningful centroid; the divider output is discarded.
  function automatic logic [LOC_W-1:0] gate_loc(input logic [LOC_W-1:0] loc,
                                               input logic [OBJ_W-1:0] area);
    gate_loc = (area == '0) ? '0 : loc;
  endfunction

  assign last_label = (obj_id == (n_lat - WORD_W'(1)));
  assign keep_label = !AREA_FILTER || (obj_area >= OBJ_W'(MIN_AREA));
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    n_lat_nxt     = n_lat;
    obj_id_nxt    = obj_id;
    out_valid_nxt = out_valid;
    out_label_nxt = out_label;
    out_x_nxt     = out_x;
    out_y_nxt     = out_y;
    obj_count_nxt = obj_count;
    done_nxt      = 1'b0;
    ccl_en        = 1'b0;

    case (state)
      S_IDLE: begin
        if (frame_start) begin
          state_nxt     = S_SCAN;
          obj_count_nxt = '0;
        end
      end

      S_SCAN: begin
        ccl_en = pix_valid;
        if (frame_end) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end

      S_DRAIN: begin
        ccl_en = 1'b1;
        if (cnt == '0) begin
          n_lat_nxt = num_labels;
          if (num_labels <= WORD_W'(1)) begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            obj_id_nxt = WORD_W'(1);
            cnt_nxt    = CNT_W'(READ_LAT - 1);
            state_nxt  = S_FETCH;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      S_FETCH: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (keep_label) begin
          out_label_nxt = obj_id;
          out_x_nxt     = gate_loc(obj_x, obj_area);
          out_y_nxt     = gate_loc(obj_y, obj_area);
          out_valid_nxt = 1'b1;
          state_nxt     = S_EMIT;
        end else if (last_label) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          // Skipped label: one extra cycle keeps the per-label cost at READ_LAT+1.
          obj_id_nxt = obj_id + WORD_W'(1);
          cnt_nxt    = CNT_W'(READ_LAT);
        end
      end

      S_EMIT: begin
        if (out_ready) begin
          obj_count_nxt = obj_count + WORD_W'(1);
          out_valid_nxt = 1'b0;
          if (last_label) begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            obj_id_nxt = obj_id + WORD_W'(1);
            cnt_nxt    = CNT_W'(READ_LAT - 1);
            state_nxt  = S_FETCH;
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      n_lat     <= '0;
      obj_id    <= '0;
      out_valid <= 1'b0;
      out_label <= '0;
      out_x     <= '0;
      out_y     <= '0;
      obj_count <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      n_lat     <= n_lat_nxt;
      obj_id    <= obj_id_nxt;
      out_valid <= out_valid_nxt;
      out_label <= out_label_nxt;
      out_x     <= out_x_nxt;
      out_y     <= out_y_nxt;
      obj_count <= obj_count_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_ccl_readout_ctrl.sv
// Self-checking bench for ccl_readout_ctrl: directed frames against a record-list model of the readout.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef LOC_SIZE
`define LOC_SIZE 10
`endif
`ifndef OBJ_WIDTH
`define OBJ_WIDTH 16
`endif

module tb_ccl_readout_ctrl;
  localparam int WORD_W   = `WORD_SIZE;
  localparam int LOC_W    = `LOC_SIZE;
  localparam int OBJ_W    = `OBJ_WIDTH;
  localparam int MIN_AREA = 16;
`ifdef CCL_AREA_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, frame_start, frame_end, pix_valid, out_ready;
  logic [WORD_W-1:0] num_labels;
  logic [LOC_W-1:0]  obj_x, obj_y;
  logic [OBJ_W-1:0]  obj_area;
  logic              ccl_en, out_valid, busy, done;
  logic [WORD_W-1:0] obj_id, out_label, obj_count;
  logic [LOC_W-1:0]  out_x, out_y;

  logic [LOC_W-1:0]  x_tab    [256];
  logic [LOC_W-1:0]  y_tab    [256];
  logic [OBJ_W-1:0]  area_tab [256];

  typedef struct {
    int label;
    int x;
    int y;
  } rec_t;

  rec_t exp_q[$];
  int   hs_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   exp_n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data table with a one-cycle read: settles before the edge after obj_id changes.
  assign obj_x    = x_tab[obj_id];
  assign obj_y    = y_tab[obj_id];
  assign obj_area = area_tab[obj_id];

  ccl_readout_ctrl dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .num_labels(num_labels), .obj_x(obj_x), .obj_y(obj_y),
    .obj_area(obj_area), .ccl_en(ccl_en), .obj_id(obj_id), .out_valid(out_valid),
    .out_ready(out_ready), .out_label(out_label), .out_x(out_x), .out_y(out_y),
    .busy(busy), .done(done), .obj_count(obj_count)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_obj(input int k, input int x, input int y, input int a);
    x_tab[k] = LOC_W'(x);
    y_tab[k] = LOC_W'(y);
    area_tab[k] = OBJ_W'(a);
  endtask

  // Records the frame must produce: labels 1..n-1 in order, empty objects report 0,0.
  task automatic build_exp(input int n);
    rec_t r;
    exp_q.delete();
    hs_cyc.delete();
    for (int k = 1; k < n; k++) begin
      if (!(FILTER && area_tab[k] < MIN_AREA)) begin
        r.label = k;
        r.x = (area_tab[k] == 0) ? 0 : int'(x_tab[k]);
        r.y = (area_tab[k] == 0) ? 0 : int'(y_tab[k]);
        exp_q.push_back(r);
      end
    end
    exp_n = exp_q.size();
  endtask

  task automatic scan_frame(input int n);
    num_labels = WORD_W'(n);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pix_valid = 1'b1;
    step();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (!done && i < 200) begin
      step();
      i++;
    end
    check({name, "_done_seen"}, int'(done), 1);
  endtask

  task automatic wait_valid(input string name);
    int i;
    i = 0;
    while (!out_valid && i < 200) begin
      step();
      i++;
    end
    check({name, "_valid_seen"}, int'(out_valid), 1);
  endtask

  // Stream monitor: every accepted record must be the next one the model predicts.
  rec_t mon_e;
  logic mon_held = 1'b0;
  int   mon_lbl, mon_x, mon_y;
  always @(negedge clk) begin
    if (!reset) begin
      if (mon_held && out_valid) begin
        check("hold_label", int'(out_label), mon_lbl);
        check("hold_x", int'(out_x), mon_x);
        check("hold_y", int'(out_y), mon_y);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_record", int'(out_label), -1);
        end else begin
          mon_e = exp_q.pop_front();
          check("rec_label", int'(out_label), mon_e.label);
          check("rec_x", int'(out_x), mon_e.x);
          check("rec_y", int'(out_y), mon_e.y);
        end
        hs_cyc.push_back(cyc);
      end
      mon_held = out_valid && !out_ready;
      mon_lbl  = int'(out_label);
      mon_x    = int'(out_x);
      mon_y    = int'(out_y);
    end else begin
      mon_held = 1'b0;
    end
  end

  logic [7:0] pv_pat;
  int cap_lbl, cap_x, cap_y, cap_id;

  initial begin
    for (int k = 0; k < 256; k++) set_obj(k, 0, 0, 0);
    reset = 1'b1; frame_start = 1'b0; frame_end = 1'b0; pix_valid = 1'b0;
    out_ready = 1'b1; num_labels = '0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_ccl_en", int'(ccl_en), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_obj_id", int'(obj_id), 0);
    check("rst_obj_count", int'(obj_count), 0);
    check("rst_done", int'(done), 0);

    // No objects: drain only, then done.
    build_exp(1);
    num_labels = WORD_W'(1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pix_valid = 1'b1;
    frame_end = 1'b1;
    #1;
    check("t2_end_pixel_en", int'(ccl_en), 1);
    step();
    frame_end = 1'b0;
    pix_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_en", int'(ccl_en), 1);
      step();
    end
    check("t2_done", int'(done), 1);
    check("t2_en_off", int'(ccl_en), 0);
    check("t2_busy", int'(busy), 0);
    check("t2_count", int'(obj_count), 0);
    step();
    check("t2_done_pulse", int'(done), 0);

    // Three labels streamed back to back.
    set_obj(1, 11, 21, 20);
    set_obj(2, 12, 22, 30);
    set_obj(3, 13, 23, 40);
    build_exp(4);
    check("t3_model_size", exp_n, 3);
    check("t3_model_first_x", exp_q[0].x, 11);
    scan_frame(4);
    wait_done("t3");
    check("t3_count", int'(obj_count), 3);
    check("t3_all_emitted", exp_q.size(), 0);
    check("t3_hs_count", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      check("t3_spacing_a", hs_cyc[1] - hs_cyc[0], 2);
      check("t3_spacing_b", hs_cyc[2] - hs_cyc[1], 2);
    end
    step();

    // Backpressure: record must stay put while out_ready is low.
    set_obj(1, 101, 201, 50);
    set_obj(2, 102, 202, 60);
    build_exp(3);
    out_ready = 1'b0;
    scan_frame(3);
    wait_valid("t4");
    cap_lbl = int'(out_label); cap_x = int'(out_x); cap_y = int'(out_y); cap_id = int'(obj_id);
    check("t4_first_label", cap_lbl, 1);
    check("t4_first_x", cap_x, 101);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_stall_label", int'(out_label), cap_lbl);
      check("t4_stall_x", int'(out_x), cap_x);
      check("t4_stall_y", int'(out_y), cap_y);
      check("t4_stall_obj_id", int'(obj_id), cap_id);
      check("t4_stall_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    wait_done("t4");
    check("t4_count", int'(obj_count), 2);
    check("t4_all_emitted", exp_q.size(), 0);
    step();

    // ccl_en follows pix_valid during the scan; a stray frame_start in FETCH is ignored.
    build_exp(3);
    num_labels = WORD_W'(3);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pv_pat = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      pix_valid = pv_pat[i];
      #1;
      check("t5_en_tracks", int'(ccl_en), int'(pv_pat[i]));
      step();
    end
    pix_valid = 1'b0;
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    repeat (4) step();
    frame_start = 1'b1;
    #1;
    check("t5_fetch_obj_id", int'(obj_id), 1);
    check("t5_fetch_en", int'(ccl_en), 0);
    step();
    frame_start = 1'b0;
    wait_done("t5");
    check("t5_count", int'(obj_count), 2);
    check("t5_all_emitted", exp_q.size(), 0);
    pix_valid = 1'b1;
    #1;
    check("t5_idle_en", int'(ccl_en), 0);
    pix_valid = 1'b0;
    step();

    // Mixed areas including an empty object.
    set_obj(1, 31, 41, 20);
    set_obj(2, 32, 42, 5);
    set_obj(3, 99, 77, 0);
    set_obj(4, 34, 44, 40);
    build_exp(5);
    if (FILTER) begin
      check("t6_model_size", exp_n, 2);
      check("t6_model_second", exp_q[1].label, 4);
    end else begin
      check("t6_model_size", exp_n, 4);
      check("t6_model_zero_x", exp_q[2].x, 0);
    end
    scan_frame(5);
    wait_done("t6");
    check("t6_count", int'(obj_count), exp_n);
    check("t6_all_emitted", exp_q.size(), 0);
    step();

    // Reset while a record is pending.
    set_obj(1, 7, 8, 50);
    set_obj(2, 9, 10, 50);
    build_exp(3);
    out_ready = 1'b0;
    scan_frame(3);
    wait_valid("t1");
    reset = 1'b1;
    step();
    check("t1_valid", int'(out_valid), 0);
    check("t1_busy", int'(busy), 0);
    check("t1_obj_id", int'(obj_id), 0);
    check("t1_en", int'(ccl_en), 0);
    reset = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    step();
    check("t1_idle_valid", int'(out_valid), 0);
    check("t1_idle_count", int'(obj_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
